// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start bit, DATA_BITS data bits (LSB first),
// optional even/odd parity, 1 or 2 stop bits. Every output comes from a register.
module uart_tx_param #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Done,
  output logic                 o_Tx_Ready
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic          ODD_PAR   = (PARITY == 2);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PARITY  = 3'd3,
    ST_STOP    = 3'd4,
    ST_CLEANUP = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [DATA_BITS-1:0] data_sh;
  logic                 par_q, par_d;
  logic                 serial_d, active_d, done_d, ready_d;
  logic                 bit_end;

  assign bit_end = (cnt_q == CNT_LAST);
  assign data_sh = data_q >> idx_d;

  // State register and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      par_q       <= 1'b0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
      o_Tx_Ready  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      par_q       <= par_d;
      o_Tx_Serial <= serial_d;
      o_Tx_Active <= active_d;
      o_Tx_Done   <= done_d;
      o_Tx_Ready  <= ready_d;
    end
  end

  // Next state, counters and next register values of the outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    par_d    = par_q;
    active_d = o_Tx_Active;
    done_d   = 1'b0;
    ready_d  = 1'b0;
    serial_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        cnt_d   = '0;
        idx_d   = '0;
        if (i_Tx_DV) begin
          data_d   = i_Tx_Byte;
          par_d    = (^i_Tx_Byte) ^ ODD_PAR;
          active_d = 1'b1;
          ready_d  = 1'b0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == STOP_LAST) begin
            idx_d    = '0;
            active_d = 1'b0;
            done_d   = 1'b1;
            state_d  = ST_CLEANUP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_CLEANUP: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d    = '0;
        idx_d    = '0;
        active_d = 1'b0;
        ready_d  = 1'b1;
        state_d  = ST_IDLE;
      end
    endcase

    // Line level follows the state being entered so it changes only at bit boundaries
    case (state_d)
      ST_START:  serial_d = 1'b0;
      ST_DATA:   serial_d = data_sh[0];
      ST_PARITY: serial_d = par_q;
      default:   serial_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Randomised bench for uart_tx_param: three parameter sets, each frame checked
// cycle by cycle against a bit-list model built from the frame format rules.
module tb_uart_tx_param;

  logic       clk;
  logic       rst;
  logic [2:0] dv;
  logic [8:0] byte_in [3];
  logic [2:0] serial_o, active_o, done_o, ready_o;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_param u_def (
    .i_clk(clk), .i_rst(rst), .i_Tx_DV(dv[0]), .i_Tx_Byte(byte_in[0][7:0]),
    .o_Tx_Serial(serial_o[0]), .o_Tx_Active(active_o[0]),
    .o_Tx_Done(done_o[0]), .o_Tx_Ready(ready_o[0])
  );

  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_even (
    .i_clk(clk), .i_rst(rst), .i_Tx_DV(dv[1]), .i_Tx_Byte(byte_in[1][6:0]),
    .o_Tx_Serial(serial_o[1]), .o_Tx_Active(active_o[1]),
    .o_Tx_Done(done_o[1]), .o_Tx_Ready(ready_o[1])
  );

  uart_tx_param #(.CLKS_PER_BIT(3), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_odd (
    .i_clk(clk), .i_rst(rst), .i_Tx_DV(dv[2]), .i_Tx_Byte(byte_in[2][7:0]),
    .o_Tx_Serial(serial_o[2]), .o_Tx_Active(active_o[2]),
    .o_Tx_Done(done_o[2]), .o_Tx_Ready(ready_o[2])
  );

  function automatic int cpb_of(input int d);
    case (d) 0: return 868; 1: return 4; default: return 3; endcase
  endfunction
  function automatic int dbits_of(input int d);
    return (d == 1) ? 7 : 8;
  endfunction
  function automatic int par_of(input int d);
    case (d) 0: return 0; 1: return 1; default: return 2; endcase
  endfunction
  function automatic int stop_of(input int d);
    return (d == 1) ? 2 : 1;
  endfunction

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Sends one frame on DUT d and checks every cycle up to the following IDLE.
  // A second request with byte ib is injected at frame cycle inject_at (0 = none).
  task automatic send_frame(input int d, input logic [8:0] b, input int inject_at,
                            input logic [8:0] ib);
    int   cpb, frame, cyc, bad, done_cyc, ones, w;
    logic exp_bits[$];
    cpb = cpb_of(d);
    ones = 0;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < dbits_of(d); i++) begin
      exp_bits.push_back(b[i]);
      ones += int'(b[i]);
    end
    if (par_of(d) == 1) exp_bits.push_back(ones % 2 == 1);
    if (par_of(d) == 2) exp_bits.push_back(ones % 2 == 0);
    for (int i = 0; i < stop_of(d); i++) exp_bits.push_back(1'b1);
    frame = exp_bits.size() * cpb;

    w = 0;
    while (ready_o[d] !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_eq($sformatf("ready_before_req[%0d]", d), int'(ready_o[d]), 1);
    dv[d] = 1'b1;
    byte_in[d] = b;
    @(negedge clk);
    dv[d] = 1'b0;
    byte_in[d] = 9'($urandom);

    cyc = 1;
    done_cyc = -1;
    foreach (exp_bits[k]) begin
      bad = 0;
      for (int c = 0; c < cpb; c++) begin
        if (serial_o[d] !== exp_bits[k] || active_o[d] !== 1'b1 || ready_o[d] !== 1'b0)
          bad++;
        if (done_o[d] === 1'b1 && done_cyc < 0) done_cyc = cyc;
        if (cyc == inject_at) begin
          dv[d] = 1'b1;
          byte_in[d] = ib;
        end
        @(negedge clk);
        dv[d] = 1'b0;
        cyc++;
      end
      check_eq($sformatf("dut%0d_bit%0d_bad_cycles", d, k), bad, 0);
    end

    if (done_o[d] === 1'b1 && done_cyc < 0) done_cyc = cyc;
    check_eq($sformatf("dut%0d_done_latency", d), done_cyc, frame + 1);
    check_eq($sformatf("dut%0d_cleanup_line", d), int'(serial_o[d]), 1);
    check_eq($sformatf("dut%0d_cleanup_active", d), int'(active_o[d]), 0);
    check_eq($sformatf("dut%0d_cleanup_ready", d), int'(ready_o[d]), 0);
    @(negedge clk);
    check_eq($sformatf("dut%0d_idle_done_low", d), int'(done_o[d]), 0);
    check_eq($sformatf("dut%0d_idle_ready", d), int'(ready_o[d]), 1);
    check_eq($sformatf("dut%0d_idle_line", d), int'(serial_o[d]), 1);
  endtask

  initial begin
    logic [8:0] b;
    int bad;
    rst = 1'b1;
    dv  = '0;
    for (int d = 0; d < 3; d++) byte_in[d] = '0;

    #1;
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("rst_line[%0d]", d), int'(serial_o[d]), 1);
      check_eq($sformatf("rst_active[%0d]", d), int'(active_o[d]), 0);
      check_eq($sformatf("rst_done[%0d]", d), int'(done_o[d]), 0);
      check_eq($sformatf("rst_ready[%0d]", d), int'(ready_o[d]), 1);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Default parameters: 0x55 then one random byte
    send_frame(0, 9'h055, 0, 9'h0);
    send_frame(0, 9'($urandom), 0, 9'h0);

    // Even parity, 7 data bits, 2 stop bits: 0x41, back-to-back randoms, mid-frame request
    send_frame(1, 9'h041, 0, 9'h0);
    for (int i = 0; i < 4; i++) send_frame(1, 9'($urandom), 0, 9'h0);
    b = 9'($urandom);
    send_frame(1, b, 10, ~b);
    send_frame(1, b, 30, 9'h07F);

    // Odd parity, 8 data bits
    send_frame(2, 9'h0FF, 0, 9'h0);
    send_frame(2, 9'h000, 0, 9'h0);
    send_frame(2, 9'h001, 0, 9'h0);
    for (int i = 0; i < 4; i++) send_frame(2, 9'($urandom), 0, 9'h0);

    // Reset in the middle of the DATA phase of DUT 1
    dv[1] = 1'b1;
    byte_in[1] = 9'h000;
    @(negedge clk);
    dv[1] = 1'b0;
    repeat (3 * 4 + 1) @(negedge clk);
    check_eq("pre_reset_active", int'(active_o[1]), 1);
    check_eq("pre_reset_line_data0", int'(serial_o[1]), 0);
    rst = 1'b1;
    #1;
    check_eq("mid_reset_line", int'(serial_o[1]), 1);
    check_eq("mid_reset_active", int'(active_o[1]), 0);
    check_eq("mid_reset_ready", int'(ready_o[1]), 1);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done_o[1] !== 1'b0) bad++;
    end
    check_eq("mid_reset_no_done", bad, 0);
    rst = 1'b0;
    send_frame(1, 9'($urandom), 0, 9'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, clocks per bit period (legal range 2..65535).
REQ-002 The block SHALL have parameter DATA_BITS, default 8, data bits per frame (legal range 5..9).
REQ-003 The block SHALL have parameter PARITY, default 0, parity mode (0 none, 1 even, 2 odd).
REQ-004 The block SHALL have parameter STOP_BITS, default 1, stop bits per frame (legal values 1 or 2).
REQ-005 The block SHALL have port i_clk, input, width 1, the single clock; all state changes occur on its rising edge.
REQ-006 The block SHALL have port i_rst, input, width 1, reset that is asynchronous and active-high.
REQ-007 The block SHALL have port i_Tx_DV, input, width 1, a one-cycle request to send i_Tx_Byte.
REQ-008 The block SHALL have port i_Tx_Byte, input, width DATA_BITS, the payload, sent LSB first.
REQ-009 The block SHALL have port o_Tx_Serial, output, width 1, the serial line, which idles high.
REQ-010 The block SHALL have port o_Tx_Active, output, width 1, high from request acceptance through the last stop bit.
REQ-011 The block SHALL have port o_Tx_Done, output, width 1, a one-cycle pulse at frame completion.
REQ-012 The block SHALL have port o_Tx_Ready, output, width 1, high when a request on i_Tx_DV will be accepted.

Function
REQ-013 The block SHALL use a state machine with states IDLE, START, DATA, PARITY, STOP and CLEANUP; every unused encoding SHALL go to IDLE on the next cycle.
REQ-014 In IDLE, the block SHALL drive o_Tx_Ready=1, o_Tx_Serial=1, clear the bit counter and clear the bit index.
REQ-015 When i_Tx_DV=1 in IDLE, the block SHALL latch i_Tx_Byte, compute parity on the latched byte, set o_Tx_Active=1, clear o_Tx_Ready and enter START on the next edge.
REQ-016 The block SHALL ignore i_Tx_DV in every state other than IDLE; the latched data SHALL remain unchanged until the frame ends.
REQ-017 Each bit period SHALL last exactly CLKS_PER_BIT clocks, counted 0..CLKS_PER_BIT-1 by a counter of width $clog2(CLKS_PER_BIT).
REQ-018 The START state SHALL drive o_Tx_Serial=0 for one bit period.
REQ-019 The DATA state SHALL send bits 0..DATA_BITS-1 in order, one bit period each, with a bit index of width $clog2(DATA_BITS+1).
REQ-020 After the last data bit, the block SHALL enter PARITY if PARITY!=0, otherwise STOP.
REQ-021 The PARITY state SHALL send the XOR of the data bits for even mode (PARITY=1) and its inverse for odd mode (PARITY=2), for one bit period.
REQ-022 The STOP state SHALL drive o_Tx_Serial=1 for STOP_BITS bit periods.
REQ-023 At the end of STOP, the block SHALL deassert o_Tx_Active, pulse o_Tx_Done=1 for exactly one cycle and enter CLEANUP.
REQ-024 CLEANUP SHALL last one cycle with o_Tx_Serial=1 and then return to IDLE.
REQ-025 Request-to-request minimum spacing SHALL be frame_clocks+2 cycles, where frame_clocks=(1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT.
REQ-026 The first START clock SHALL occur on the cycle after the request is accepted.
REQ-027 Data-bit transitions SHALL occur only at bit-period boundaries; o_Tx_Serial SHALL be glitch-free because it is driven directly from a register.

Reset
REQ-028 While i_rst=1, the block SHALL immediately (asynchronously) force state=IDLE, o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=1, counters=0 and latched data=0.
REQ-029 If reset is asserted mid-frame, the block SHALL abort the frame with no o_Tx_Done pulse and return the line high within the same cycle.
REQ-030 After reset deasserts, the block SHALL accept a request on the first rising edge.

Verification
REQ-031 Default params, i_Tx_Byte=0x55 -> line sequence 0,1,0,1,0,1,0,1,0,1, each bit 868 clocks; o_Tx_Done pulses once, 8681 clocks after acceptance.
REQ-032 CLKS_PER_BIT=4, DATA_BITS=7, PARITY=1, STOP_BITS=2, byte 0x41 -> start, 1000001, parity 0, stop 1,1; frame is 44 clocks.
REQ-033 PARITY=2, DATA_BITS=8, byte 0xFF -> parity bit 1; byte 0x00 -> parity bit 1; byte 0x01 -> parity bit 0.
REQ-034 A second i_Tx_DV mid-frame with a different byte -> ignored; the first frame is unaltered and o_Tx_Ready stays 0.
REQ-035 Reset asserted in the middle of the DATA state -> o_Tx_Serial=1 and o_Tx_Active=0 immediately, no o_Tx_Done; a new frame sends correctly after release.
REQ-036 Back-to-back requests issued as soon as o_Tx_Ready rises -> two complete frames separated by exactly one idle (CLEANUP) high cycle plus one IDLE cycle.
